// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: bus widths, bundle layouts,
// load-op encodings and the MS state encoding.
// Ports: none (package).
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 77;
  localparam int MS_TO_WS_BUS_WD = 73;
  localparam int STALL_BUS_WD    = 9;
  localparam int FORWARD_BUS_WD  = 33;

  localparam logic [2:0] LOP_NONE = 3'b000;
  localparam logic [2:0] LOP_LB   = 3'b001;
  localparam logic [2:0] LOP_LBU  = 3'b010;
  localparam logic [2:0] LOP_LH   = 3'b011;
  localparam logic [2:0] LOP_LHU  = 3'b100;
  localparam logic [2:0] LOP_LW   = 3'b101;

  // EX -> MS bundle, MSB first: req[76], load_op[75:73], gr_we[72:69],
  // dest[68:64], alu_result[63:32], pc[31:0].
  typedef struct packed {
    logic        req;
    logic [2:0]  load_op;
    logic [3:0]  gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_to_ms_t;

  // MS -> WS bundle: gr_we[72:69], dest[68:64], final_result[63:32], pc[31:0].
  typedef struct packed {
    logic [3:0]  gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_to_ws_t;

  typedef enum logic [1:0] {
    MS_EMPTY = 2'd0,
    MS_WAIT  = 2'd1,
    MS_READY = 2'd2
  } ms_state_e;

  // Encodings 11x are reserved and behave like a non-load.
  function automatic logic is_load(input logic [2:0] op);
    return (op != LOP_NONE) && (op[2:1] != 2'b11);
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the byte/halfword/word addressed by addr and
// sign- or zero-extends it. Purely combinational, no backpressure.
// Ports: load_op_i (encoding), addr_i (low address bits), raw_i (SRAM word), result_o.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  load_op_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] raw_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = raw_i[7:0];
    case (addr_i)
      2'd1:    byte_sel = raw_i[15:8];
      2'd2:    byte_sel = raw_i[23:16];
      2'd3:    byte_sel = raw_i[31:24];
      default: byte_sel = raw_i[7:0];
    endcase
  end

  // addr_i[0] is don't-care for halfwords: misalignment is trapped upstream.
  assign half_sel = addr_i[1] ? raw_i[31:16] : raw_i[15:0];

  always_comb begin
    result_o = raw_i;
    case (load_op_i)
      LOP_LB:  result_o = {{24{byte_sel[7]}}, byte_sel};
      LOP_LBU: result_o = {24'b0, byte_sel};
      LOP_LH:  result_o = {{16{half_sel[15]}}, half_sel};
      LOP_LHU: result_o = {16'b0, half_sel};
      default: result_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds the EX bundle, waits for the data-SRAM
// response, aligns load data and hands the result to WB.
// Latency 1 cycle for non-memory ops, max(1, data_ok) for memory ops; WB
// backpressure holds the bundle, buffering the response in rbuf if needed.
// Ports: clk/resetn; EX side es_to_ms_valid/es_to_ms_bus/ms_allowin; SRAM side
// data_sram_data_ok/data_sram_rdata; WB side ms_to_ws_valid/ms_to_ws_bus/
// ws_allowin; ID side stall_ms_bus/forward_ms_bus.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       resetn,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       ws_allowin,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [STALL_BUS_WD-1:0]    stall_ms_bus,
  output logic [FORWARD_BUS_WD-1:0]  forward_ms_bus
);

  ms_state_e   state_q;
  logic        ms_valid_q;
  logic        rbuf_v_q;
  logic [31:0] rbuf_q;
  es_to_ms_t   bus_q;
  es_to_ms_t   es_in;

  logic        data_ok_eff;
  logic        ms_ready_go;
  logic [31:0] raw_data;
  logic [31:0] load_result;
  logic [31:0] final_result;
  ms_to_ws_t   ws_out;

  assign es_in = es_to_ms_t'(es_to_ms_bus);

  // A response only counts while a request is outstanding; stray strobes are dropped.
  assign data_ok_eff = data_sram_data_ok & (state_q == MS_WAIT);

  assign ms_ready_go    = ~bus_q.req | data_ok_eff | rbuf_v_q;
  assign ms_allowin     = ~ms_valid_q | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid_q & ms_ready_go;

  // Any cycle with ms_allowin=1 either is idle or hands the bundle to WB, so
  // the state is reloaded from the incoming bundle and rbuf is released.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= MS_EMPTY;
      ms_valid_q <= 1'b0;
      rbuf_v_q   <= 1'b0;
      rbuf_q     <= 32'b0;
      bus_q      <= '0;
    end else if (ms_allowin) begin
      ms_valid_q <= es_to_ms_valid;
      rbuf_v_q   <= 1'b0;
      if (es_to_ms_valid) begin
        bus_q   <= es_in;
        state_q <= es_in.req ? MS_WAIT : MS_READY;
      end else begin
        state_q <= MS_EMPTY;
      end
    end else if (data_ok_eff) begin
      // Response arrived but WB is blocked: hold it until the hand-off.
      state_q  <= MS_READY;
      rbuf_v_q <= 1'b1;
      rbuf_q   <= data_sram_rdata;
    end
  end

  assign raw_data = data_ok_eff ? data_sram_rdata : rbuf_q;

  load_align u_load_align (
    .load_op_i (bus_q.load_op),
    .addr_i    (bus_q.alu_result[1:0]),
    .raw_i     (raw_data),
    .result_o  (load_result)
  );

  // Stores and non-memory ops forward alu_result; store data is discarded.
  assign final_result = is_load(bus_q.load_op) ? load_result : bus_q.alu_result;

  assign ws_out.gr_we        = bus_q.gr_we;
  assign ws_out.dest         = bus_q.dest;
  assign ws_out.final_result = final_result;
  assign ws_out.pc           = bus_q.pc;
  assign ms_to_ws_bus        = ws_out;

  // A pending load keeps gr_we visible on the stall bus but not forwardable.
  assign stall_ms_bus   = {({4{ms_valid_q}} & bus_q.gr_we), bus_q.dest};
  assign forward_ms_bus = {ms_to_ws_valid, final_result};

`ifndef SYNTHESIS
  // A response with nothing outstanding means the SRAM side lost track of requests.
  a_no_stray_data_ok: assert property (
    @(posedge clk) disable iff (!resetn) data_sram_data_ok |-> (state_q == MS_WAIT)
  );
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a per-cycle vector table plus hand-written
// back-pressure, back-to-back and asynchronous-reset sequences.
// Ports: none (top-level bench).
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic         clk;
  logic         resetn;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [76:0]  es_to_ms_bus;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         ws_allowin;
  logic         ms_to_ws_valid;
  logic [72:0]  ms_to_ws_bus;
  logic [8:0]   stall_ms_bus;
  logic [32:0]  forward_ms_bus;

  int vectors;
  int miscompares;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ws_allowin        (ws_allowin),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .stall_ms_bus      (stall_ms_bus),
    .forward_ms_bus    (forward_ms_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         es_v;
    logic [76:0]  es_bus;
    logic         dok;
    logic [31:0]  rdata;
    logic         wsa;
    logic [127:0] exp;
    logic         full;
  } vec_t;

  localparam int NROWS = 14;
  localparam int NB2B  = 6;
  vec_t tbl [NROWS];

  // Output word layout: {allowin, valid, ws_bus[72:0], stall[8:0], fwd[32:0]}.
  localparam logic [127:0] MASK_FULL = {11'b0, {117{1'b1}}};
  localparam logic [127:0] MASK_CTL  = {11'b0, 2'b11, 73'b0, 4'hF, 5'b0, 1'b1, 32'b0};

  function automatic logic [76:0] mk_es(input logic req, input logic [2:0] op,
                                        input logic [3:0] we, input logic [4:0] dest,
                                        input logic [31:0] alu, input logic [31:0] pc);
    return {req, op, we, dest, alu, pc};
  endfunction

  function automatic logic [72:0] mk_ws(input logic [3:0] we, input logic [4:0] dest,
                                        input logic [31:0] res, input logic [31:0] pc);
    return {we, dest, res, pc};
  endfunction

  function automatic logic [127:0] mk_exp(input logic a, input logic v, input logic [72:0] ws,
                                          input logic [8:0] st, input logic [32:0] fw);
    return {11'b0, a, v, ws, st, fw};
  endfunction

  function automatic vec_t mkv(input logic es_v, input logic [76:0] es_bus, input logic dok,
                               input logic [31:0] rdata, input logic wsa,
                               input logic [127:0] exp, input logic full);
    vec_t r;
    r.es_v = es_v; r.es_bus = es_bus; r.dok = dok; r.rdata = rdata;
    r.wsa = wsa; r.exp = exp; r.full = full;
    return r;
  endfunction

  function automatic logic [127:0] dut_out();
    return {11'b0, ms_allowin, ms_to_ws_valid, ms_to_ws_bus, stall_ms_bus, forward_ms_bus};
  endfunction

  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp,
                     input logic [127:0] mask);
    vectors++;
    if (((act ^ exp) & mask) !== 128'b0) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (mask %h)", name, act & mask, exp & mask, mask);
    end
  endtask

  task automatic drive(input logic es_v, input logic [76:0] bus, input logic dok,
                       input logic [31:0] rd, input logic wsa);
    es_to_ms_valid    = es_v;
    es_to_ms_bus      = bus;
    data_sram_data_ok = dok;
    data_sram_rdata   = rd;
    ws_allowin        = wsa;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [76:0] b_alu, b_lb, b_lhu, b_lh, b_lbu, b_x, b_lw, b_alu2, b_lb2, b_alu3;
  int  idx, outn, cyc;
  logic pend, acc;
  logic [31:0] exp_res, exp_pc;

  initial begin
    vectors = 0;
    miscompares = 0;

    b_alu  = mk_es(1'b0, LOP_NONE, 4'hF, 5'd5,  32'h1234_5678, 32'h100);
    b_lb   = mk_es(1'b1, LOP_LB,   4'hF, 5'd7,  32'h0000_1003, 32'h104);
    b_lhu  = mk_es(1'b1, LOP_LHU,  4'hF, 5'd3,  32'h0000_2002, 32'h108);
    b_lh   = mk_es(1'b1, LOP_LH,   4'hF, 5'd3,  32'h0000_2002, 32'h10C);
    b_lbu  = mk_es(1'b1, LOP_LBU,  4'h1, 5'd9,  32'h0000_3001, 32'h110);
    b_x    = mk_es(1'b0, 3'b110,   4'h3, 5'd10, 32'hCAFE_F00D, 32'h114);
    b_lw   = mk_es(1'b1, LOP_LW,   4'hF, 5'd8,  32'h0000_4000, 32'h200);
    b_alu2 = mk_es(1'b0, LOP_NONE, 4'hF, 5'd9,  32'h0000_0077, 32'h204);
    b_lb2  = mk_es(1'b1, LOP_LB,   4'hF, 5'd6,  32'h0000_0010, 32'h400);
    b_alu3 = mk_es(1'b0, LOP_NONE, 4'h2, 5'd4,  32'h0000_ABCD, 32'h500);

    tbl[0]  = mkv(0, '0,    0, 0, 1, mk_exp(1, 0, '0, 9'h000, 33'h0), 1);
    tbl[1]  = mkv(1, b_alu, 0, 0, 1, mk_exp(1, 0, '0, 9'h000, 33'h0), 1);
    tbl[2]  = mkv(0, '0,    0, 0, 1, mk_exp(1, 1, mk_ws(4'hF, 5'd5, 32'h1234_5678, 32'h100),
                                            9'h1E5, {1'b1, 32'h1234_5678}), 1);
    tbl[3]  = mkv(1, b_lb,  0, 0, 1, mk_exp(1, 0, '0, 9'h000, 33'h0), 0);
    tbl[4]  = mkv(0, '0,    0, 0, 1, mk_exp(0, 0, mk_ws(4'hF, 5'd7, 32'h0, 32'h104),
                                            9'h1E7, {1'b0, 32'h0}), 1);
    tbl[5]  = tbl[4];
    tbl[6]  = mkv(0, '0, 1, 32'h80FF_0000, 1, mk_exp(1, 1, mk_ws(4'hF, 5'd7, 32'hFFFF_FF80, 32'h104),
                                            9'h1E7, {1'b1, 32'hFFFF_FF80}), 1);
    tbl[7]  = mkv(1, b_lhu, 0, 0, 1, mk_exp(1, 0, '0, 9'h000, 33'h0), 0);
    tbl[8]  = mkv(0, '0, 1, 32'h8001_1234, 1, mk_exp(1, 1, mk_ws(4'hF, 5'd3, 32'h0000_8001, 32'h108),
                                            9'h1E3, {1'b1, 32'h0000_8001}), 1);
    tbl[9]  = mkv(1, b_lh,  0, 0, 1, mk_exp(1, 0, '0, 9'h000, 33'h0), 0);
    tbl[10] = mkv(0, '0, 1, 32'h8001_1234, 1, mk_exp(1, 1, mk_ws(4'hF, 5'd3, 32'hFFFF_8001, 32'h10C),
                                            9'h1E3, {1'b1, 32'hFFFF_8001}), 1);
    tbl[11] = mkv(1, b_lbu, 0, 0, 1, mk_exp(1, 0, '0, 9'h000, 33'h0), 0);
    tbl[12] = mkv(1, b_x, 1, 32'h0000_9A00, 1, mk_exp(1, 1, mk_ws(4'h1, 5'd9, 32'h0000_009A, 32'h110),
                                            9'h029, {1'b1, 32'h0000_009A}), 1);
    tbl[13] = mkv(0, '0, 0, 0, 1, mk_exp(1, 1, mk_ws(4'h3, 5'd10, 32'hCAFE_F00D, 32'h114),
                                            9'h06A, {1'b1, 32'hCAFE_F00D}), 1);

    // Reset state.
    resetn = 1'b0;
    drive(0, '0, 0, 0, 1);
    step();
    cmp("reset", dut_out(), mk_exp(1, 0, '0, 9'h000, 33'h0), MASK_FULL);
    resetn = 1'b1;

    for (int i = 0; i < NROWS; i++) begin
      drive(tbl[i].es_v, tbl[i].es_bus, tbl[i].dok, tbl[i].rdata, tbl[i].wsa);
      #3;
      cmp($sformatf("row%0d", i), dut_out(), tbl[i].exp, tbl[i].full ? MASK_FULL : MASK_CTL);
      step();
    end

    // Back-pressure: response latched while WB is blocked, SRAM bus then changes.
    drive(1, b_lw, 0, 0, 1);
    #3;
    cmp("bp_accept", dut_out(), mk_exp(1, 0, '0, 9'h000, 33'h0), MASK_CTL);
    step();
    drive(0, '0, 1, 32'h1122_3344, 0);
    #3;
    cmp("bp_dataok", dut_out(), mk_exp(0, 1, mk_ws(4'hF, 5'd8, 32'h1122_3344, 32'h200),
                                       9'h1E8, {1'b1, 32'h1122_3344}), MASK_FULL);
    step();
    for (int k = 0; k < 3; k++) begin
      drive(1, b_alu2, 0, 32'hDEAD_BEEF, 0);
      #3;
      cmp($sformatf("bp_hold%0d", k), dut_out(),
          mk_exp(0, 1, mk_ws(4'hF, 5'd8, 32'h1122_3344, 32'h200), 9'h1E8, {1'b1, 32'h1122_3344}),
          MASK_FULL);
      step();
    end
    drive(1, b_alu2, 0, 32'hDEAD_BEEF, 1);
    #3;
    cmp("bp_release", dut_out(), mk_exp(1, 1, mk_ws(4'hF, 5'd8, 32'h1122_3344, 32'h200),
                                        9'h1E8, {1'b1, 32'h1122_3344}), MASK_FULL);
    step();
    drive(0, '0, 0, 0, 1);
    #3;
    cmp("bp_next", dut_out(), mk_exp(1, 1, mk_ws(4'hF, 5'd9, 32'h0000_0077, 32'h204),
                                     9'h1E9, {1'b1, 32'h0000_0077}), MASK_FULL);
    step();

    // Back-to-back ALU / store alternation; store responses arrive one cycle after acceptance.
    idx = 0; outn = 0; cyc = 0; pend = 1'b0;
    while (outn < NB2B && cyc < 40) begin
      drive(idx < NB2B,
            (idx % 2 == 1) ? mk_es(1'b1, LOP_NONE, 4'h0, 5'(idx), 32'h5000 + 32'(idx), 32'h300 + 32'(4 * idx))
                           : mk_es(1'b0, LOP_NONE, 4'hF, 5'(idx), 32'h1000 + 32'(idx), 32'h300 + 32'(4 * idx)),
            pend, 32'h5A5A_5A5A, 1);
      #3;
      cmp($sformatf("b2b_allowin_c%0d", cyc), 128'(ms_allowin), 128'(1), 128'(1));
      if (ms_to_ws_valid) begin
        exp_pc  = 32'h300 + 32'(4 * outn);
        exp_res = ((outn % 2) == 1) ? 32'h5000 + 32'(outn) : 32'h1000 + 32'(outn);
        cmp($sformatf("b2b_out%0d", outn), 128'(ms_to_ws_bus[63:0]), 128'({exp_res, exp_pc}),
            128'({64{1'b1}}));
        outn++;
      end
      acc = ms_allowin & (idx < NB2B);
      step();
      pend = acc & (idx % 2 == 1);
      if (acc) idx++;
      cyc++;
    end
    cmp("b2b_count", 128'(outn), 128'(NB2B), 128'({32{1'b1}}));
    drive(0, '0, 0, 0, 1);
    #3;
    cmp("b2b_drain", 128'(ms_to_ws_valid), 128'(0), 128'(1));
    step();

    // Asynchronous reset while a load waits for its response.
    drive(1, b_lb2, 0, 0, 1);
    step();
    drive(0, '0, 0, 0, 1);
    #3;
    cmp("rst_wait", dut_out(), mk_exp(0, 0, '0, {4'hF, 5'd0}, 33'h0), MASK_CTL);
    #1;
    resetn = 1'b0;
    #1;
    cmp("rst_async", dut_out(), mk_exp(1, 0, '0, 9'h000, 33'h0), MASK_FULL);
    step();
    cmp("rst_hold", dut_out(), mk_exp(1, 0, '0, 9'h000, 33'h0), MASK_FULL);
    resetn = 1'b1;
    drive(1, b_alu3, 0, 0, 1);
    #3;
    cmp("rst_after", dut_out(), mk_exp(1, 0, '0, 9'h000, 33'h0), MASK_FULL);
    step();
    drive(0, '0, 0, 0, 1);
    #3;
    cmp("rst_first", dut_out(), mk_exp(1, 1, mk_ws(4'h2, 5'd4, 32'h0000_ABCD, 32'h500),
                                       9'h044, {1'b1, 32'h0000_ABCD}), MASK_FULL);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
